wav_dfi_hs_checker: RTL and testbench
=====================================

Name: wav_dfi_hs_checker

Overview:
- Synthesizable, parametrised DFI handshake and protocol checker.
- Passively monitors the DFI control handshakes (lp_ctrl, lp_data, ctrlupd, phyupd, phymstr), init_start and the per-phase command/data enables.
- Flags violations in sticky error bits, a saturating error counter and a first-error ID, all readable by CSR logic.
- Sits beside the DFI boundary in emulation/silicon debug builds; no simulation-only constructs.

Parameters:
- NUM_PHASES, 4, number of DFI phases on address/wrdata_en/rddata_en.
- ADDR_W, 14, per-phase address width.
- TLP_RESP, 8, cycles an lp req may wait unacknowledged before it must drop.
- TPHYUPD_RESP, 16, max cycles from phyupd_req rise to phyupd_ack.
- TCTRLUPD_RESP, 32, max cycles from ctrlupd_req rise to ctrlupd_ack.
- TPHYMSTR_RESP, 32, max cycles from phymstr_req rise to phymstr_ack.
- CNT_W, 8, width of err_count.

Ports:
- clock  in  1  DFI clock.
- reset  in  1  asynchronous, active-low reset.
- lp_ctrl_req/lp_ctrl_ack  in  1 each  low-power control handshake.
- lp_data_req/lp_data_ack  in  1 each  low-power data handshake.
- ctrlupd_req/ctrlupd_ack  in  1 each  controller update handshake.
- phyupd_req/phyupd_ack  in  1 each  PHY update handshake.
- phymstr_req/phymstr_ack  in  1 each  PHY master handshake.
- init_start  in  1  init request.
- address  in  NUM_PHASES*ADDR_W  flattened, phase 0 in LSBs.
- wrdata_en  in  NUM_PHASES  per-phase write enable.
- rddata_en  in  NUM_PHASES  per-phase read enable.
- clear  in  1  synchronous clear of all error state.
- err_vec  out  16  sticky error bits, indexed by error ID.
- err_count  out  CNT_W  saturating count of error events.
- first_err_id  out  4  ID of first error since reset/clear.
- first_err_vld  out  1  first_err_id is valid.
- irq  out  1  registered OR of err_vec.

Behaviour:
- Reset (reset=0, asynchronous) and clear (synchronous, highest priority): all outputs 0, all FSMs IDLE, all counters 0.
- Per-handshake FSM states:
  - IDLE: req=1 -> WAIT; ack=1 -> ERR_ACK_NO_REQ.
  - WAIT: counts cycles with req & ~ack; ack=1 -> ACKED; req=0 with ack=0 -> IDLE (abandon, legal). If count reaches RESP_MAX and req & ~ack persist the next cycle -> RESP_TIMEOUT, flagged once per request, state stays WAIT.
  - ACKED: req=0 -> RELEASE; ack=0 while req=1 -> ACKED_DROP (ack withdrawn early).
  - RELEASE: ack must be 0 the cycle after req fell; otherwise LATE_ACK_DROP and stay in RELEASE until ack=0. Then -> IDLE. req rising while ack=1 -> REQ_REASSERT.
- Error IDs (err_vec bit):
  - 0 lp_ctrl timeout; 1 lp_ctrl late ack drop.
  - 2 lp_data timeout; 3 lp_data late ack drop.
  - 4 phyupd timeout; 5 phyupd late ack drop; 6 phyupd req reassert.
  - 7 ctrlupd ack without req; 8 ctrlupd timeout.
  - 9 phymstr timeout.
  - 10 forbidden pair: phyupd_ack&phymstr_ack, ctrlupd_req&phyupd_ack, or init_start with phyupd_ack/phymstr_ack/ctrlupd_req/lp_ctrl_req/lp_data_req.
  - 11 bus not idle: any address phase nonzero while phyupd_ack or ctrlupd_ack.
  - 12 lp_data_req with any wrdata_en or rddata_en bit.
  - 13 lp_ctrl_req with any address phase nonzero.
  - 14 ack without req on lp_ctrl/lp_data/phyupd/phymstr.
  - 15 reserved, reads 0.
- Error event: any ID detected in a cycle. err_vec bits set one cycle later and stay set.
- err_count: increments by 1 per cycle with at least one new detection (not per bit); saturates at 2^CNT_W-1.
- first_err_id: captured on the first event. If several IDs fire simultaneously, the lowest ID wins. first_err_vld set with it; both hold until reset/clear.
- Level-type checks (10-13) fire every violating cycle and count every cycle.
- RESP_MAX of 0 disables that handshake's timeout.
- Counters are sized $clog2(RESP_MAX+2) and never wrap.
- clear asserted in the same cycle as a detection: clear wins, the event is dropped.
- Latency: detection to err_vec/irq is exactly 1 cycle.

Decomposition:
- Package wav_dfi_chk_pkg holds: the err_id_e enum (16 entries above), the hs_state_e enum {IDLE, WAIT, ACKED, RELEASE}, and the ERR_W=16 constant.
- Sub-module wav_dfi_hs_fsm:
  - Parameter RESP_MAX; inputs clock, reset, clear, req, ack.
  - Outputs err_timeout, err_late_drop, err_reassert, err_ack_no_req.
  - Instantiated 5 times.
- The top level holds the forbidden-pair/idle logic, the priority encoder and the counters.

Test Plan:
- lp_ctrl_req=1 held with ack=0 for TLP_RESP+1 cycles -> err_vec[0]=1 one cycle later, err_count=1, first_err_id=0, irq=1.
- phyupd_req rises, ack at cycle 16 -> no error. Ack at cycle 17 -> err_vec[4]=1. Req drop with ack still high 2 cycles later -> err_vec[5]=1.
- ctrlupd_ack=1 with ctrlupd_req=0 for 3 cycles -> err_vec[7]=1, err_count=1 (FSM event once), first_err_id=7.
- phyupd_ack=1 while address phase 2 = 14'h0040 for 5 cycles -> err_vec[11]=1, err_count=5. 300 such cycles with CNT_W=8 -> err_count=255.
- Same cycle: lp_data_req=1, wrdata_en=4'b0100, init_start=1 -> err_vec[10] and [12] set, err_count=1, first_err_id=10.
- Assert reset mid-handshake (phyupd in ACKED), release -> all outputs 0. Next cycle ack=1/req=1 -> FSM starts from IDLE, flags ID 14 only.

Source files
------------

// File: rtl/wav_dfi_chk_pkg.sv
// Shared types for the DFI handshake checker: error IDs, handshake FSM
// states and the lowest-ID priority encoder used for first-error capture.
package wav_dfi_chk_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [3:0] {
        ERR_LPC_TIMEOUT        = 4'd0,
        ERR_LPC_LATE_DROP      = 4'd1,
        ERR_LPD_TIMEOUT        = 4'd2,
        ERR_LPD_LATE_DROP      = 4'd3,
        ERR_PHYUPD_TIMEOUT     = 4'd4,
        ERR_PHYUPD_LATE_DROP   = 4'd5,
        ERR_PHYUPD_REASSERT    = 4'd6,
        ERR_CTRLUPD_ACK_NO_REQ = 4'd7,
        ERR_CTRLUPD_TIMEOUT    = 4'd8,
        ERR_PHYMSTR_TIMEOUT    = 4'd9,
        ERR_FORBIDDEN_PAIR     = 4'd10,
        ERR_BUS_NOT_IDLE       = 4'd11,
        ERR_LPD_DATA_EN        = 4'd12,
        ERR_LPC_ADDR           = 4'd13,
        ERR_ACK_NO_REQ         = 4'd14,
        ERR_RSVD               = 4'd15
    } err_id_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACKED   = 2'd2,
        RELEASE = 2'd3
    } hs_state_e;

    // Lowest set bit wins when several errors fire in the same cycle.
    function automatic logic [3:0] lowest_id(input logic [ERR_W-1:0] v);
        logic [3:0] id;
        id = '0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (v[i]) id = 4'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/wav_dfi_hs_fsm.sv
// Passive monitor for one DFI req/ack handshake. Tracks the handshake phase
// and raises single-cycle detection pulses for protocol violations.
module wav_dfi_hs_fsm
    import wav_dfi_chk_pkg::*;
#(
    parameter int RESP_MAX = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic req,
    input  logic ack,
    output logic err_timeout,
    output logic err_late_drop,
    output logic err_reassert,
    output logic err_ack_no_req
);

    // One extra code above RESP_MAX marks "timeout already reported".
    localparam int CW = $clog2(RESP_MAX + 2);
    localparam logic [CW-1:0] MAX_C  = CW'(RESP_MAX);
    localparam logic [CW-1:0] DONE_C = CW'(RESP_MAX + 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    hs_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          anr_flg_q;
    logic          late_flg_q;
    logic          reas_flg_q;

    // Detection is decoded from the current state and live inputs so the
    // top-level error registers land exactly one cycle after the violation.
    always_comb begin
        err_timeout    = (RESP_MAX != 0) && (state_q == WAIT) && req && !ack
                         && (cnt_q == MAX_C);
        err_ack_no_req = (state_q == IDLE) && ack && !anr_flg_q;
        err_late_drop  = (state_q == RELEASE) && ack && !late_flg_q;
        err_reassert   = (state_q == RELEASE) && ack && req && !reas_flg_q;
    end

    // Handshake state, response counter and once-per-episode report flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            anr_flg_q  <= 1'b0;
            late_flg_q <= 1'b0;
            reas_flg_q <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            anr_flg_q  <= 1'b0;
            late_flg_q <= 1'b0;
            reas_flg_q <= 1'b0;
        end else begin
            anr_flg_q  <= (state_q == IDLE) && ack && !req;
            late_flg_q <= (state_q == RELEASE) && ack;
            reas_flg_q <= (state_q == RELEASE) && ack && req;
            case (state_q)
                IDLE: begin
                    // The rising cycle of req already counts as one wait cycle.
                    if (req) begin
                        state_q <= ack ? ACKED : WAIT;
                        cnt_q   <= ONE_C;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        state_q <= ACKED;
                        cnt_q   <= '0;
                    end else if (!req) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (RESP_MAX != 0) begin
                        if (cnt_q == MAX_C) begin
                            cnt_q <= DONE_C;
                        end else if (cnt_q != DONE_C) begin
                            cnt_q <= cnt_q + ONE_C;
                        end
                    end
                end
                ACKED: begin
                    // Ack withdrawn while req still high: treat as pending again.
                    if (!req) begin
                        state_q <= RELEASE;
                    end else if (!ack) begin
                        state_q <= WAIT;
                        cnt_q   <= ONE_C;
                    end
                end
                RELEASE: begin
                    if (!ack) begin
                        state_q <= req ? WAIT : IDLE;
                        cnt_q   <= req ? ONE_C : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wav_dfi_hs_checker.sv
// DFI handshake/protocol checker: five handshake monitors plus level checks
// on forbidden signal pairs and idle bus, feeding sticky error CSR state.
module wav_dfi_hs_checker
    import wav_dfi_chk_pkg::*;
#(
    parameter int NUM_PHASES    = 4,
    parameter int ADDR_W        = 14,
    parameter int TLP_RESP      = 8,
    parameter int TPHYUPD_RESP  = 16,
    parameter int TCTRLUPD_RESP = 32,
    parameter int TPHYMSTR_RESP = 32,
    parameter int CNT_W         = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         lp_ctrl_req,
    input  logic                         lp_ctrl_ack,
    input  logic                         lp_data_req,
    input  logic                         lp_data_ack,
    input  logic                         ctrlupd_req,
    input  logic                         ctrlupd_ack,
    input  logic                         phyupd_req,
    input  logic                         phyupd_ack,
    input  logic                         phymstr_req,
    input  logic                         phymstr_ack,
    input  logic                         init_start,
    input  logic [NUM_PHASES*ADDR_W-1:0] address,
    input  logic [NUM_PHASES-1:0]        wrdata_en,
    input  logic [NUM_PHASES-1:0]        rddata_en,
    input  logic                         clear,
    output logic [ERR_W-1:0]             err_vec,
    output logic [CNT_W-1:0]             err_count,
    output logic [3:0]                   first_err_id,
    output logic                         first_err_vld,
    output logic                         irq
);

    logic lpc_to, lpc_late, lpc_reas, lpc_anr;
    logic lpd_to, lpd_late, lpd_reas, lpd_anr;
    logic pu_to,  pu_late,  pu_reas,  pu_anr;
    logic cu_to,  cu_late,  cu_reas,  cu_anr;
    logic pm_to,  pm_late,  pm_reas,  pm_anr;

    wav_dfi_hs_fsm #(.RESP_MAX(TLP_RESP)) u_lp_ctrl (
        .clock(clock), .reset(reset), .clear(clear),
        .req(lp_ctrl_req), .ack(lp_ctrl_ack),
        .err_timeout(lpc_to), .err_late_drop(lpc_late),
        .err_reassert(lpc_reas), .err_ack_no_req(lpc_anr)
    );

    wav_dfi_hs_fsm #(.RESP_MAX(TLP_RESP)) u_lp_data (
        .clock(clock), .reset(reset), .clear(clear),
        .req(lp_data_req), .ack(lp_data_ack),
        .err_timeout(lpd_to), .err_late_drop(lpd_late),
        .err_reassert(lpd_reas), .err_ack_no_req(lpd_anr)
    );

    wav_dfi_hs_fsm #(.RESP_MAX(TPHYUPD_RESP)) u_phyupd (
        .clock(clock), .reset(reset), .clear(clear),
        .req(phyupd_req), .ack(phyupd_ack),
        .err_timeout(pu_to), .err_late_drop(pu_late),
        .err_reassert(pu_reas), .err_ack_no_req(pu_anr)
    );

    wav_dfi_hs_fsm #(.RESP_MAX(TCTRLUPD_RESP)) u_ctrlupd (
        .clock(clock), .reset(reset), .clear(clear),
        .req(ctrlupd_req), .ack(ctrlupd_ack),
        .err_timeout(cu_to), .err_late_drop(cu_late),
        .err_reassert(cu_reas), .err_ack_no_req(cu_anr)
    );

    wav_dfi_hs_fsm #(.RESP_MAX(TPHYMSTR_RESP)) u_phymstr (
        .clock(clock), .reset(reset), .clear(clear),
        .req(phymstr_req), .ack(phymstr_ack),
        .err_timeout(pm_to), .err_late_drop(pm_late),
        .err_reassert(pm_reas), .err_ack_no_req(pm_anr)
    );

    // Monitor outputs that have no error ID assigned.
    logic unused_fsm_outs;
    assign unused_fsm_outs = &{1'b0, lpc_reas, lpd_reas, cu_late, cu_reas, pm_late, pm_reas};

    logic [NUM_PHASES-1:0] phase_nz;
    logic                  addr_nz;
    logic [ERR_W-1:0]      det;

    // Per-phase nonzero address detection.
    always_comb begin
        phase_nz = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            phase_nz[p] = |address[p*ADDR_W +: ADDR_W];
        end
        addr_nz = |phase_nz;
    end

    // Collect this cycle's detections, indexed by error ID.
    always_comb begin
        det = '0;
        det[ERR_LPC_TIMEOUT]        = lpc_to;
        det[ERR_LPC_LATE_DROP]      = lpc_late;
        det[ERR_LPD_TIMEOUT]        = lpd_to;
        det[ERR_LPD_LATE_DROP]      = lpd_late;
        det[ERR_PHYUPD_TIMEOUT]     = pu_to;
        det[ERR_PHYUPD_LATE_DROP]   = pu_late;
        det[ERR_PHYUPD_REASSERT]    = pu_reas;
        det[ERR_CTRLUPD_ACK_NO_REQ] = cu_anr;
        det[ERR_CTRLUPD_TIMEOUT]    = cu_to;
        det[ERR_PHYMSTR_TIMEOUT]    = pm_to;
        det[ERR_FORBIDDEN_PAIR]     = (phyupd_ack && phymstr_ack)
                                   || (ctrlupd_req && phyupd_ack)
                                   || (init_start && (phyupd_ack || phymstr_ack || ctrlupd_req
                                                      || lp_ctrl_req || lp_data_req));
        det[ERR_BUS_NOT_IDLE]       = addr_nz && (phyupd_ack || ctrlupd_ack);
        det[ERR_LPD_DATA_EN]        = lp_data_req && ((|wrdata_en) || (|rddata_en));
        det[ERR_LPC_ADDR]           = lp_ctrl_req && addr_nz;
        det[ERR_ACK_NO_REQ]         = lpc_anr || lpd_anr || pu_anr || pm_anr;
        det[ERR_RSVD]               = 1'b0;
    end

    logic [ERR_W-1:0] err_vec_q,   err_vec_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [3:0]       first_id_q,  first_id_d;
    logic             first_vld_q, first_vld_d;
    logic             irq_q,       irq_d;

    // Next-state of the sticky error bits, event counter and first-error capture.
    always_comb begin
        err_vec_d   = err_vec_q | det;
        err_count_d = err_count_q;
        if ((|det) && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
        first_id_d  = first_id_q;
        first_vld_d = first_vld_q;
        if (!first_vld_q && (|det)) begin
            first_id_d  = lowest_id(det);
            first_vld_d = 1'b1;
        end
        irq_d = |err_vec_d;
    end

    // Error CSR state; clear overrides any detection in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_vec_q   <= '0;
            err_count_q <= '0;
            first_id_q  <= '0;
            first_vld_q <= 1'b0;
            irq_q       <= 1'b0;
        end else if (clear) begin
            err_vec_q   <= '0;
            err_count_q <= '0;
            first_id_q  <= '0;
            first_vld_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            err_vec_q   <= err_vec_d;
            err_count_q <= err_count_d;
            first_id_q  <= first_id_d;
            first_vld_q <= first_vld_d;
            irq_q       <= irq_d;
        end
    end

    assign err_vec       = err_vec_q;
    assign err_count     = err_count_q;
    assign first_err_id  = first_id_q;
    assign first_err_vld = first_vld_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_wav_dfi_hs_checker.sv
// Scenario bench for wav_dfi_hs_checker with an expectation queue.
module tb_wav_dfi_hs_checker;

    localparam int NP = 4;
    localparam int AW = 14;

    logic          clock;
    logic          reset;
    logic          lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack;
    logic          ctrlupd_req, ctrlupd_ack, phyupd_req, phyupd_ack;
    logic          phymstr_req, phymstr_ack, init_start, clear;
    logic [NP*AW-1:0] address;
    logic [NP-1:0] wrdata_en, rddata_en;
    logic [15:0]   err_vec;
    logic [7:0]    err_count;
    logic [3:0]    first_err_id;
    logic          first_err_vld, irq;

    typedef struct packed {
        logic [15:0] vec;
        logic [7:0]  cnt;
        logic [3:0]  id;
        logic        vld;
        logic        irq;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } sb_t;

    sb_t  sb_q[$];
    obs_t obs;
    int   checks   = 0;
    int   failures = 0;

    assign obs = {err_vec, err_count, first_err_id, first_err_vld, irq};

    wav_dfi_hs_checker dut (
        .clock(clock), .reset(reset),
        .lp_ctrl_req(lp_ctrl_req), .lp_ctrl_ack(lp_ctrl_ack),
        .lp_data_req(lp_data_req), .lp_data_ack(lp_data_ack),
        .ctrlupd_req(ctrlupd_req), .ctrlupd_ack(ctrlupd_ack),
        .phyupd_req(phyupd_req), .phyupd_ack(phyupd_ack),
        .phymstr_req(phymstr_req), .phymstr_ack(phymstr_ack),
        .init_start(init_start), .address(address),
        .wrdata_en(wrdata_en), .rddata_en(rddata_en), .clear(clear),
        .err_vec(err_vec), .err_count(err_count), .first_err_id(first_err_id),
        .first_err_vld(first_err_vld), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic obs_t mk(input logic [15:0] v, input logic [7:0] c, input logic [3:0] id);
        mk = {v, c, id, (v != 16'h0), (v != 16'h0)};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_inputs();
        lp_ctrl_req = 0; lp_ctrl_ack = 0; lp_data_req = 0; lp_data_ack = 0;
        ctrlupd_req = 0; ctrlupd_ack = 0; phyupd_req = 0; phyupd_ack = 0;
        phymstr_req = 0; phymstr_ack = 0; init_start = 0;
        address = '0; wrdata_en = '0; rddata_en = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        sb_t e;
        idle_inputs();
        clear = 1'b0;
        reset = 1'b0;
        ctrlupd_ack = 1'b1;
        sb_q.push_back('{name: "reset_state", exp: mk(16'h0, 8'd0, 4'd0)});
        step(2);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        ctrlupd_ack = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_lp_ctrl_timeout();
        sb_t e;
        do_clear();
        lp_ctrl_req = 1'b1;
        sb_q.push_back('{name: "lpc_before_timeout", exp: mk(16'h0, 8'd0, 4'd0)});
        step(8);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        sb_q.push_back('{name: "lpc_timeout", exp: mk(16'h0001, 8'd1, 4'd0)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        sb_q.push_back('{name: "lpc_timeout_once", exp: mk(16'h0001, 8'd1, 4'd0)});
        step(4);
        lp_ctrl_req = 1'b0;
        step(2);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
    endtask

    task automatic test_phyupd();
        sb_t e;
        do_clear();
        // ack on cycle 16 after the rise is still in time
        phyupd_req = 1'b1;
        step(16);
        phyupd_ack = 1'b1;
        step(1);
        phyupd_req = 1'b0;
        step(1);
        phyupd_ack = 1'b0;
        sb_q.push_back('{name: "phyupd_ack_in_time", exp: mk(16'h0, 8'd0, 4'd0)});
        step(2);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        // ack on cycle 17 is late
        phyupd_req = 1'b1;
        sb_q.push_back('{name: "phyupd_edge_no_err", exp: mk(16'h0, 8'd0, 4'd0)});
        step(16);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        sb_q.push_back('{name: "phyupd_timeout", exp: mk(16'h0010, 8'd1, 4'd4)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        phyupd_ack = 1'b1;
        step(1);
        phyupd_req = 1'b0;
        step(2);
        phyupd_ack = 1'b0;
        sb_q.push_back('{name: "phyupd_late_drop", exp: mk(16'h0030, 8'd2, 4'd4)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        // req re-raised while ack still high from the previous handshake
        do_clear();
        phyupd_req = 1'b1;
        step(1);
        phyupd_ack = 1'b1;
        step(1);
        phyupd_req = 1'b0;
        step(1);
        phyupd_req = 1'b1;
        step(1);
        phyupd_req = 1'b0;
        phyupd_ack = 1'b0;
        sb_q.push_back('{name: "phyupd_reassert", exp: mk(16'h0060, 8'd1, 4'd5)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
    endtask

    task automatic test_ctrlupd_ack_no_req();
        sb_t e;
        do_clear();
        ctrlupd_ack = 1'b1;
        step(3);
        ctrlupd_ack = 1'b0;
        sb_q.push_back('{name: "ctrlupd_ack_no_req", exp: mk(16'h0080, 8'd1, 4'd7)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
    endtask

    task automatic test_bus_not_idle();
        sb_t e;
        logic [NP*AW-1:0] a;
        do_clear();
        a = '0;
        a[2*AW +: AW] = 14'h0040;
        address = a;
        phyupd_ack = 1'b1;
        sb_q.push_back('{name: "bus_not_idle_5", exp: mk(16'h4800, 8'd5, 4'd11)});
        step(5);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        sb_q.push_back('{name: "count_saturate", exp: mk(16'h4800, 8'd255, 4'd11)});
        step(295);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        idle_inputs();
        step(1);
    endtask

    task automatic test_simultaneous();
        sb_t e;
        do_clear();
        lp_data_req = 1'b1;
        wrdata_en   = 4'b0100;
        init_start  = 1'b1;
        step(1);
        idle_inputs();
        sb_q.push_back('{name: "simultaneous_ids", exp: mk(16'h1400, 8'd1, 4'd10)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
    endtask

    task automatic test_reset_mid_handshake();
        sb_t e;
        do_clear();
        ctrlupd_ack = 1'b1;
        step(1);
        ctrlupd_ack = 1'b0;
        phyupd_req  = 1'b1;
        step(1);
        phyupd_ack  = 1'b1;
        step(1);
        #2 reset = 1'b0;
        #1;
        sb_q.push_back('{name: "async_reset", exp: mk(16'h0, 8'd0, 4'd0)});
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        idle_inputs();
        step(1);
        reset = 1'b1;
        step(1);
        phyupd_req = 1'b1;
        phyupd_ack = 1'b1;
        sb_q.push_back('{name: "post_reset_ack_no_req", exp: mk(16'h4000, 8'd1, 4'd14)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
    endtask

    task automatic test_clear_priority();
        sb_t e;
        idle_inputs();
        ctrlupd_ack = 1'b1;
        clear = 1'b1;
        sb_q.push_back('{name: "clear_wins", exp: mk(16'h0, 8'd0, 4'd0)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        clear = 1'b0;
        ctrlupd_ack = 1'b0;
        sb_q.push_back('{name: "clear_event_dropped", exp: mk(16'h0, 8'd0, 4'd0)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        do_clear();
        lp_data_req = 1'b1;
        ctrlupd_req = 1'b1;
        phymstr_req = 1'b1;
        sb_q.push_back('{name: "lpd_timeout", exp: mk(16'h0004, 8'd1, 4'd2)});
        step(9);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        sb_q.push_back('{name: "upd_mstr_edge", exp: mk(16'h0004, 8'd1, 4'd2)});
        step(23);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        sb_q.push_back('{name: "upd_mstr_timeout", exp: mk(16'h0304, 8'd2, 4'd2)});
        step(1);
        e = sb_q.pop_front(); checks++;
        if (obs !== e.exp) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.exp); end
        idle_inputs();
        step(1);
    endtask

    initial begin
        test_reset();
        test_lp_ctrl_timeout();
        test_phyupd();
        test_ctrlupd_ack_no_req();
        test_bus_not_idle();
        test_simultaneous();
        test_reset_mid_handshake();
        test_clear_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
